// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

    localparam int unsigned DATA_W_DEF = 160;
    localparam int unsigned CTRL_W_DEF = 16;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    // ID/EX payload as packed by the decode stage; width matches DATA_W_DEF.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_entry.sv
// One payload/control register slot with load and independent clears.
module pipe_entry #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear_ctrl,
    input  logic              i_clear_data,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    // Clears win over a load in the same cycle.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (i_load) begin
            data_d = i_data;
            ctrl_d = i_ctrl;
        end
        if (i_clear_ctrl) begin
            ctrl_d = '0;
        end
        if (i_clear_data) begin
            data_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign o_data = data_q;
    assign o_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and flush.
// Optional performance counters enabled by PIPE_SKID_STAGE_PERF_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned CTRL_W          = CTRL_W_DEF,
    parameter bit          FLUSH_ZERO_DATA = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    skid_state_e state_d, state_q;

    logic              push, pop;
    logic              main_load, main_clr_ctrl, main_from_skid;
    logic              skid_load, skid_clr_ctrl, clr_data;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;

    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != TWO) & ~i_rst;
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr_ctrl  = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr_ctrl  = 1'b0;
        clr_data       = 1'b0;
        if (i_flush) begin
            state_d       = EMPTY;
            main_clr_ctrl = 1'b1;
            skid_clr_ctrl = 1'b1;
            clr_data      = FLUSH_ZERO_DATA;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d       = EMPTY;
                        main_clr_ctrl = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr_ctrl  = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_data_in = main_from_skid ? skid_data : i_data;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : i_ctrl;

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (main_load),
        .i_clear_ctrl (main_clr_ctrl),
        .i_clear_data (clr_data),
        .i_data       (main_data_in),
        .i_ctrl       (main_ctrl_in),
        .o_data       (main_data),
        .o_ctrl       (main_ctrl)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (skid_load),
        .i_clear_ctrl (skid_clr_ctrl),
        .i_clear_data (clr_data),
        .i_data       (i_data),
        .i_ctrl       (i_ctrl),
        .o_data       (skid_data),
        .o_ctrl       (skid_ctrl)
    );

    assign o_data = main_data;
    assign o_ctrl = o_valid ? main_ctrl : CTRL_W'(CTRL_NOP);

`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // Saturating: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_valid && !i_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (i_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
